// File: rtl/game_tick_scheduler_if.sv
// -----------------------------------------------------------------------------
// game_tick_scheduler_if
//
// Purpose:
//   Bundles the frame/score inputs and the tick/step outputs of the game tick
//   scheduler into a single interface. The scheduler connects through the
//   slave modport. The block driving the inputs and reading the ticks (or a
//   testbench) connects through the master modport.
//
// Signals:
//   i_frame_start       one-cycle pulse at the start of vertical blanking
//   i_game_start_pulse  one-cycle pulse when a new game begins
//   i_game_frozen       high while the game is over or waiting to start
//   i_score[15:0]       4-digit BCD score, [15:12] = thousands
//   o_tick_60hz         one-cycle pulse every frame
//   o_tick_20hz[1:0]    [0] every FRAME_DIV frames, [1] = [0] delayed 1 cycle
//   o_obs_step          obstacle advance pulse, 1+level per frame
//   o_level[1:0]        current difficulty level
//   o_busy              high while a step burst is in progress
// -----------------------------------------------------------------------------
interface game_tick_scheduler_if;
  logic        i_frame_start;
  logic        i_game_start_pulse;
  logic        i_game_frozen;
  logic [15:0] i_score;
  logic        o_tick_60hz;
  logic [1:0]  o_tick_20hz;
  logic        o_obs_step;
  logic [1:0]  o_level;
  logic        o_busy;

  modport master (
    output i_frame_start,
    output i_game_start_pulse,
    output i_game_frozen,
    output i_score,
    input  o_tick_60hz,
    input  o_tick_20hz,
    input  o_obs_step,
    input  o_level,
    input  o_busy
  );

  modport slave (
    input  i_frame_start,
    input  i_game_start_pulse,
    input  i_game_frozen,
    input  i_score,
    output o_tick_60hz,
    output o_tick_20hz,
    output o_obs_step,
    output o_level,
    output o_busy
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// -----------------------------------------------------------------------------
// game_tick_scheduler
//
// Purpose:
//   Central scheduler for game-time events. From the one-cycle start-of-frame
//   pulse it derives the 60 Hz tick, the two-phase 20 Hz tick pair and a burst
//   of obstacle step pulses whose length grows with the difficulty level. The
//   difficulty level rises each time the hundreds digit of the BCD score
//   changes, saturating at MAX_LEVEL, and is cleared when a new game begins.
//
// Parameters:
//   FRAME_DIV  frames per 20 Hz tick (2..15)
//   MAX_LEVEL  saturation value of the difficulty level (0..3)
//   STEP_GAP   idle cycles between consecutive step pulses (1..3)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    game_tick_scheduler_if.slave: frame/score inputs, tick/step outputs
// -----------------------------------------------------------------------------
module game_tick_scheduler #(
  parameter int unsigned FRAME_DIV = 3,
  parameter int unsigned MAX_LEVEL = 3,
  parameter int unsigned STEP_GAP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  game_tick_scheduler_if.slave  bus
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [1:0] LVL_MAX  = 2'(MAX_LEVEL);
  localparam logic [1:0] GAP_LAST = 2'(STEP_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic [1:0]  gap_q, gap_d;
  logic [3:0]  div_q, div_d;
  logic [1:0]  level_q, level_d;
  logic [3:0]  latch_q, latch_d;
  logic        pending_q, pending_d;
  logic        tick60_q, tick60_d;
  logic [1:0]  tick20_q, tick20_d;

  logic        frame;
  logic        frozen;
  logic        start_seen;
  logic [3:0]  hundreds;
  logic        obs_step;
  logic        busy;
  logic        unused_score;

  assign frame        = bus.i_frame_start;
  assign frozen       = bus.i_game_frozen;
  assign hundreds     = bus.i_score[11:8];
  assign unused_score = ^{bus.i_score[15:12], bus.i_score[7:0]};

  // A game start applies at the frame edge whether it arrives in the frame
  // cycle itself or was remembered from an earlier cycle.
  assign start_seen   = bus.i_game_start_pulse | pending_q;

  // State register: every flop of the block, cleared asynchronously so a
  // reset mid-burst silences all outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= 3'd0;
      gap_q     <= 2'd0;
      div_q     <= 4'd0;
      level_q   <= 2'd0;
      latch_q   <= 4'd0;
      pending_q <= 1'b0;
      tick60_q  <= 1'b0;
      tick20_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      div_q     <= div_d;
      level_q   <= level_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      tick60_q  <= tick60_d;
      tick20_q  <= tick20_d;
    end
  end

  // Frame divider, tick generation, pending game start and difficulty level.
  // Ticks ignore frozen/start so the rest of the game keeps its time base.
  always_comb begin
    div_d     = div_q;
    level_d   = level_q;
    latch_d   = latch_q;
    pending_d = pending_q | bus.i_game_start_pulse;
    tick60_d  = frame;
    tick20_d  = {tick20_q[0], frame && (div_q == 4'd0)};

    if (frame) begin
      div_d     = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      pending_d = 1'b0;
      if (start_seen) begin
        level_d = 2'd0;
        latch_d = hundreds;
      end else if (!frozen && (hundreds != latch_q)) begin
        // Any hundreds-digit change counts once, including the 9->0 rollover.
        latch_d = hundreds;
        level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 2'd1;
      end
    end
  end

  // Step burst next-state logic. The burst length uses the level from before
  // this frame's update, except that a game start forces a single step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;

    if (frozen) begin
      state_d = IDLE;
      rem_d   = 3'd0;
      gap_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame) begin
            state_d = STEP;
            rem_d   = start_seen ? 3'd1 : {1'b0, level_q} + 3'd1;
          end
        end
        STEP: begin
          rem_d = rem_q - 3'd1;
          gap_d = 2'd0;
          state_d = (rem_q <= 3'd1) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = STEP;
          end else begin
            gap_d = gap_q + 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = 3'd0;
          gap_d   = 2'd0;
        end
      endcase
    end
  end

  // Step burst outputs. A freeze suppresses the step pulse in the very cycle
  // it appears, while busy drops one edge later with the state.
  always_comb begin
    obs_step = (state_q == STEP) && !frozen;
    busy     = (state_q != IDLE);
  end

  assign bus.o_tick_60hz = tick60_q;
  assign bus.o_tick_20hz = tick20_q;
  assign bus.o_obs_step  = obs_step;
  assign bus.o_level     = level_q;
  assign bus.o_busy      = busy;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_game_tick_scheduler
//
// Purpose:
//   Directed testbench for game_tick_scheduler with FRAME_DIV=3, MAX_LEVEL=3,
//   STEP_GAP=1. Each scenario task drives its own stimulus and compares the
//   outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_game_tick_scheduler;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .FRAME_DIV(3),
    .MAX_LEVEL(3),
    .STEP_GAP (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks      = 0;
  int passed      = 0;
  int step_total  = 0;
  int busy_total  = 0;
  int frames_seen = 0;

  // Running totals of step pulses and busy cycles, sampled mid-cycle.
  always @(negedge clk) begin
    step_total = step_total + int'(bus.o_obs_step);
    busy_total = busy_total + int'(bus.o_busy);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle frame pulse; returns 1 ns after the edge that samples it.
  task automatic do_frame();
    @(posedge clk);
    #1 bus.i_frame_start = 1'b1;
    @(posedge clk);
    #1 bus.i_frame_start = 1'b0;
    frames_seen++;
  endtask

  task automatic measure(output int steps, output int busy);
    int s0;
    int b0;
    s0 = step_total;
    b0 = busy_total;
    cycles(20);
    steps = step_total - s0;
    busy  = busy_total - b0;
  endtask

  task automatic test_reset();
    bus.i_frame_start      = 1'b0;
    bus.i_game_start_pulse = 1'b0;
    bus.i_game_frozen      = 1'b0;
    bus.i_score            = 16'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (bus.o_tick_60hz !== 1'b0) $display("[TB] FAIL reset_tick60: got %0d expected 0", bus.o_tick_60hz); else passed++;
    checks++; if (bus.o_tick_20hz !== 2'b00) $display("[TB] FAIL reset_tick20: got %0d expected 0", bus.o_tick_20hz); else passed++;
    checks++; if (bus.o_obs_step !== 1'b0) $display("[TB] FAIL reset_step: got %0d expected 0", bus.o_obs_step); else passed++;
    checks++; if (bus.o_level !== 2'd0) $display("[TB] FAIL reset_level: got %0d expected 0", bus.o_level); else passed++;
    checks++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0d expected 0", bus.o_busy); else passed++;
    cycles(3);
    rst_n = 1'b1;
    frames_seen = 0;
    cycles(3);
  endtask

  task automatic test_frame_ticks();
    logic exp20;
    for (int k = 0; k < 6; k++) begin
      exp20 = (frames_seen % 3 == 0);
      do_frame();
      checks++; if (bus.o_tick_60hz !== 1'b1) $display("[TB] FAIL ticks_60_f%0d: got %0d expected 1", k, bus.o_tick_60hz); else passed++;
      checks++; if (bus.o_tick_20hz !== {1'b0, exp20}) $display("[TB] FAIL ticks_20a_f%0d: got %0d expected %0d", k, bus.o_tick_20hz, {1'b0, exp20}); else passed++;
      checks++; if (bus.o_obs_step !== 1'b1) $display("[TB] FAIL ticks_step_f%0d: got %0d expected 1", k, bus.o_obs_step); else passed++;
      checks++; if (bus.o_busy !== 1'b1) $display("[TB] FAIL ticks_busy_f%0d: got %0d expected 1", k, bus.o_busy); else passed++;
      cycles(1);
      checks++; if (bus.o_tick_60hz !== 1'b0) $display("[TB] FAIL ticks_60off_f%0d: got %0d expected 0", k, bus.o_tick_60hz); else passed++;
      checks++; if (bus.o_tick_20hz !== {exp20, 1'b0}) $display("[TB] FAIL ticks_20b_f%0d: got %0d expected %0d", k, bus.o_tick_20hz, {exp20, 1'b0}); else passed++;
      checks++; if (bus.o_obs_step !== 1'b0) $display("[TB] FAIL ticks_stepoff_f%0d: got %0d expected 0", k, bus.o_obs_step); else passed++;
      checks++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL ticks_busyoff_f%0d: got %0d expected 0", k, bus.o_busy); else passed++;
      cycles(96);
    end
    checks++; if (bus.o_level !== 2'd0) $display("[TB] FAIL ticks_level: got %0d expected 0", bus.o_level); else passed++;
  endtask

  task automatic test_level_ramp();
    logic [15:0] scores [6] = '{16'h0099, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0400};
    int exp_level [6] = '{0, 1, 2, 3, 3, 3};
    int exp_steps [6] = '{1, 1, 2, 3, 4, 4};
    int exp_busy  [6] = '{1, 1, 3, 5, 7, 7};
    int steps;
    int busy;
    for (int i = 0; i < 6; i++) begin
      bus.i_score = scores[i];
      do_frame();
      checks++; if (int'(bus.o_level) != exp_level[i]) $display("[TB] FAIL ramp_level_%0d: got %0d expected %0d", i, bus.o_level, exp_level[i]); else passed++;
      measure(steps, busy);
      checks++; if (steps != exp_steps[i]) $display("[TB] FAIL ramp_steps_%0d: got %0d expected %0d", i, steps, exp_steps[i]); else passed++;
      checks++; if (busy != exp_busy[i]) $display("[TB] FAIL ramp_busy_%0d: got %0d expected %0d", i, busy, exp_busy[i]); else passed++;
      cycles(70);
    end
    // Step spacing at level 3: step, gap, step.
    do_frame();
    checks++; if (bus.o_obs_step !== 1'b1) $display("[TB] FAIL ramp_space_s0: got %0d expected 1", bus.o_obs_step); else passed++;
    cycles(1);
    checks++; if (bus.o_obs_step !== 1'b0 || bus.o_busy !== 1'b1) $display("[TB] FAIL ramp_space_gap: got step=%0d busy=%0d expected step=0 busy=1", bus.o_obs_step, bus.o_busy); else passed++;
    cycles(1);
    checks++; if (bus.o_obs_step !== 1'b1) $display("[TB] FAIL ramp_space_s1: got %0d expected 1", bus.o_obs_step); else passed++;
    cycles(40);
  endtask

  task automatic test_game_start();
    int steps;
    int busy;
    cycles(5);
    bus.i_game_start_pulse = 1'b1;
    cycles(1);
    bus.i_game_start_pulse = 1'b0;
    cycles(8);
    do_frame();
    checks++; if (bus.o_level !== 2'd0) $display("[TB] FAIL start_level: got %0d expected 0", bus.o_level); else passed++;
    measure(steps, busy);
    checks++; if (steps != 1) $display("[TB] FAIL start_steps: got %0d expected 1", steps); else passed++;
    cycles(60);
    bus.i_score = 16'h0450;
    do_frame();
    checks++; if (bus.o_level !== 2'd0) $display("[TB] FAIL start_same_digit: got %0d expected 0", bus.o_level); else passed++;
    measure(steps, busy);
    checks++; if (steps != 1) $display("[TB] FAIL start_same_steps: got %0d expected 1", steps); else passed++;
    cycles(60);
    bus.i_score = 16'h0500;
    do_frame();
    checks++; if (bus.o_level !== 2'd1) $display("[TB] FAIL start_pending_clr: got %0d expected 1", bus.o_level); else passed++;
    cycles(60);
    bus.i_score = 16'h0600;
    do_frame();
    checks++; if (bus.o_level !== 2'd2) $display("[TB] FAIL start_level2: got %0d expected 2", bus.o_level); else passed++;
    measure(steps, busy);
    checks++; if (steps != 2) $display("[TB] FAIL start_level2_steps: got %0d expected 2", steps); else passed++;
    cycles(60);
  endtask

  task automatic test_freeze();
    int steps;
    int busy;
    logic exp20;
    do_frame();
    checks++; if (bus.o_obs_step !== 1'b1) $display("[TB] FAIL freeze_first_step: got %0d expected 1", bus.o_obs_step); else passed++;
    cycles(1);
    bus.i_game_frozen = 1'b1;
    #1;
    checks++; if (bus.o_busy !== 1'b1) $display("[TB] FAIL freeze_busy_hold: got %0d expected 1", bus.o_busy); else passed++;
    cycles(1);
    checks++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL freeze_busy_drop: got %0d expected 0", bus.o_busy); else passed++;
    measure(steps, busy);
    checks++; if (steps != 0) $display("[TB] FAIL freeze_no_steps: got %0d expected 0", steps); else passed++;
    bus.i_score = 16'h0700;
    for (int k = 0; k < 2; k++) begin
      cycles(50);
      exp20 = (frames_seen % 3 == 0);
      do_frame();
      checks++; if (bus.o_tick_60hz !== 1'b1) $display("[TB] FAIL freeze_tick60_%0d: got %0d expected 1", k, bus.o_tick_60hz); else passed++;
      checks++; if (bus.o_tick_20hz[0] !== exp20) $display("[TB] FAIL freeze_tick20_%0d: got %0d expected %0d", k, bus.o_tick_20hz[0], exp20); else passed++;
      checks++; if (bus.o_level !== 2'd2) $display("[TB] FAIL freeze_level_%0d: got %0d expected 2", k, bus.o_level); else passed++;
      measure(steps, busy);
      checks++; if (steps != 0 || busy != 0) $display("[TB] FAIL freeze_frame_idle_%0d: got steps=%0d busy=%0d expected 0/0", k, steps, busy); else passed++;
    end
    bus.i_score = 16'h0600;
    cycles(2);
    bus.i_game_frozen = 1'b0;
    cycles(30);
  endtask

  task automatic test_back_to_back();
    int s0;
    int b0;
    logic exp20;
    s0 = step_total;
    b0 = busy_total;
    do_frame();
    cycles(1);
    exp20 = (frames_seen % 3 == 0);
    bus.i_frame_start = 1'b1;
    cycles(1);
    bus.i_frame_start = 1'b0;
    frames_seen++;
    checks++; if (bus.o_tick_60hz !== 1'b1) $display("[TB] FAIL b2b_tick60: got %0d expected 1", bus.o_tick_60hz); else passed++;
    checks++; if (bus.o_tick_20hz[0] !== exp20) $display("[TB] FAIL b2b_tick20: got %0d expected %0d", bus.o_tick_20hz[0], exp20); else passed++;
    checks++; if (bus.o_obs_step !== 1'b1) $display("[TB] FAIL b2b_second_step: got %0d expected 1", bus.o_obs_step); else passed++;
    cycles(20);
    checks++; if (step_total - s0 != 3) $display("[TB] FAIL b2b_steps: got %0d expected 3", step_total - s0); else passed++;
    checks++; if (busy_total - b0 != 5) $display("[TB] FAIL b2b_busy: got %0d expected 5", busy_total - b0); else passed++;
    checks++; if (bus.o_level !== 2'd2) $display("[TB] FAIL b2b_level: got %0d expected 2", bus.o_level); else passed++;
    cycles(60);
  endtask

  task automatic test_reset_mid_burst();
    int steps;
    int busy;
    do_frame();
    cycles(1);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %0d expected 0", bus.o_busy); else passed++;
    checks++; if (bus.o_obs_step !== 1'b0) $display("[TB] FAIL rstmid_step: got %0d expected 0", bus.o_obs_step); else passed++;
    checks++; if (bus.o_level !== 2'd0) $display("[TB] FAIL rstmid_level: got %0d expected 0", bus.o_level); else passed++;
    checks++; if (bus.o_tick_60hz !== 1'b0 || bus.o_tick_20hz !== 2'b00) $display("[TB] FAIL rstmid_ticks: got %0d/%0d expected 0/0", bus.o_tick_60hz, bus.o_tick_20hz); else passed++;
    cycles(20);
    rst_n = 1'b1;
    frames_seen = 0;
    measure(steps, busy);
    checks++; if (steps != 0 || busy != 0) $display("[TB] FAIL rstmid_quiet: got steps=%0d busy=%0d expected 0/0", steps, busy); else passed++;
    do_frame();
    checks++; if (bus.o_tick_20hz !== 2'b01) $display("[TB] FAIL rstmid_div_restart: got %0d expected 1", bus.o_tick_20hz); else passed++;
    checks++; if (bus.o_tick_60hz !== 1'b1) $display("[TB] FAIL rstmid_tick60: got %0d expected 1", bus.o_tick_60hz); else passed++;
    measure(steps, busy);
    checks++; if (steps != 1) $display("[TB] FAIL rstmid_steps: got %0d expected 1", steps); else passed++;
  endtask

  initial begin
    test_reset();
    test_frame_ticks();
    test_level_ramp();
    test_game_start();
    test_freeze();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
